// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one borrow flop, valid/ready in and out.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             bout,
   output logic             ovf
`else
   output logic             bout
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_a_sh_next;
   logic [WIDTH-1:0] w_b_sh_next;
   logic             w_br_next;
   logic [CW-1:0]    w_cnt_next;
   logic [WIDTH-1:0] w_diff_next;
   logic             w_bout_next;
   logic             w_d;
   logic             w_br_calc;
   logic             w_last;

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;
   logic w_ovf_next;
   assign ovf = r_ovf;
`endif

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign diff      = r_diff;
   assign bout      = r_bout;

   assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
   assign w_br_calc = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_state_next = r_state;
      w_a_sh_next  = r_a_sh;
      w_b_sh_next  = r_b_sh;
      w_br_next    = r_br;
      w_cnt_next   = r_cnt;
      w_diff_next  = r_diff;
      w_bout_next  = r_bout;
`ifdef SERIAL_SUB_OVF_EN
      w_ovf_next   = r_ovf;
`endif
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_a_sh_next  = a;
               w_b_sh_next  = b;
               w_br_next    = 1'b0;
               w_cnt_next   = '0;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_a_sh_next = r_a_sh >> 1;
            w_b_sh_next = r_b_sh >> 1;
            w_br_next   = w_br_calc;
            w_diff_next = {w_d, r_diff[WIDTH-1:1]};
            w_cnt_next  = r_cnt + CW'(1);
            if (w_last) begin
               w_state_next = S_DONE;
               w_bout_next  = w_br_calc;
`ifdef SERIAL_SUB_OVF_EN
               // On the last bit a_sh[0]/b_sh[0] are the operand sign bits and w_d is the result sign.
               w_ovf_next   = (r_a_sh[0] ^ r_b_sh[0]) & (w_d ^ r_a_sh[0]);
`endif
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         r_a_sh  <= w_a_sh_next;
         r_b_sh  <= w_b_sh_next;
         r_br    <= w_br_next;
         r_cnt   <= w_cnt_next;
         r_diff  <= w_diff_next;
         r_bout  <= w_bout_next;
`ifdef SERIAL_SUB_OVF_EN
         r_ovf   <= w_ovf_next;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
      .bout      (bout),
      .ovf       (ovf)
`else
      .bout      (bout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
   } exp_t;

   exp_t exp_q[$];
   int   nchecks = 0;
   int   nfail   = 0;
   int   cyc     = 0;
   int   npop    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nchecks++;
      if (act !== expv) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Monitor: every completed output transfer is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(diff), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            npop++;
            $display("txn %0d: diff=%02h bout=%0b (expect %02h/%0b)", npop, diff, bout, e.d, e.br);
            check("diff", 32'(diff), 32'(e.d));
            check("bout", 32'(bout), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ov));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'h1);
   endtask

   // Issue one operation with out_ready=1; returns cycles from accept edge to out_valid.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         output int lat);
      int n = 0;
      wait_in_ready();
      a        = ta;
      b        = tb;
      in_valid = 1'b1;
      exp_q.push_back('{d: ed, br: eb, ov: eo});
      tick();
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'h1);
      lat = n;
      tick();
   endtask

   int lat;
   int acc_cyc[4];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      tick();
      tick();
      check("in_ready_in_reset", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h1);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_diff", 32'(diff), 32'h0);
      check("rst_bout", 32'(bout), 32'h0);
      tick();

      // Basic latency and result
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, lat);
      check("latency", 32'(lat), 32'(W));
      check("in_ready_after_xfer", 32'(in_ready), 32'h1);

      run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, lat);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, lat);

      // Backpressure: result held, new operand refused
      begin
         int n = 0;
         out_ready = 1'b0;
         wait_in_ready();
         a        = 8'h40;
         b        = 8'h01;
         in_valid = 1'b1;
         exp_q.push_back('{d: 8'h3F, br: 1'b0, ov: 1'b0});
         tick();
         in_valid = 1'b0;
         while (!out_valid && n < 100) begin
            tick();
            n++;
         end
         check("bp_latency", 32'(n), 32'(W));
         a        = 8'h11;
         b        = 8'h00;
         in_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_diff_held", 32'(diff), 32'h3F);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         check("bp_in_ready_after", 32'(in_ready), 32'h1);
         check("bp_out_valid_after", 32'(out_valid), 32'h0);
      end

      // Reset mid-RUN aborts the operation
      wait_in_ready();
      a        = 8'h0F;
      b        = 8'hF0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'h1);
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (out_valid) check("abort_no_output", 32'(out_valid), 32'h0);
      end
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, lat);

      // Back-to-back with in_valid held high
      begin
         logic [W-1:0] va[4];
         logic [W-1:0] vb[4];
         logic [W-1:0] vd[4];
         logic         vbr[4];
         logic         vov[4];
         va = '{8'hA5, 8'h12, 8'h00, 8'h80};
         vb = '{8'h5A, 8'h34, 8'h01, 8'h80};
         vd = '{8'h4B, 8'hDE, 8'hFF, 8'h00};
         vbr = '{1'b0, 1'b1, 1'b1, 1'b0};
         vov = '{1'b1, 1'b0, 1'b0, 1'b0};
         in_valid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            a = va[k];
            b = vb[k];
            wait_in_ready();
            exp_q.push_back('{d: vd[k], br: vbr[k], ov: vov[k]});
            @(posedge clk);
            acc_cyc[k] = cyc;
            #1;
         end
         in_valid = 1'b0;
         for (int k = 1; k < 4; k++)
            check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(W + 2));
         for (int i = 0; i < W + 3; i++) tick();
      end

`ifdef SERIAL_SUB_OVF_EN
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, lat);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, lat);
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, lat);
`endif

      tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
      check("transfer_count", 32'(npop), 32'd12);
`else
      check("transfer_count", 32'(npop), 32'd9);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock, LSB first, with a single borrow flip-flop.
It is the subtract-direction counterpart of the combinational ripple adder in the datapath, for area-constrained ALU paths where multi-cycle latency is acceptable.
Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are 2 or more.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  operands a/b are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend (unsigned or two's complement)
b  input  WIDTH  subtrahend
out_valid  output  1  diff/bout are valid
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b modulo 2^WIDTH
bout  output  1  borrow out; 1 when unsigned a < b

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state goes to IDLE; borrow, bit counter, shift registers, diff and bout all clear to 0; out_valid is 0.
- in_ready is combinational: in_ready = (state == IDLE) and not rst. It is 0 while rst is high and 1 on the first cycle after rst falls.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: latch a into a_sh and b into b_sh, clear borrow to 0, clear count to 0, go to RUN.
  - a/b values are ignored on every cycle without an accept.
- RUN, one edge per bit (bit i processed at edge i+1 after the accept edge):
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - d shifts into the MSB of the result register; a_sh and b_sh shift right; count increments.
  - count width is $clog2(WIDTH+1).
- On the edge that processes bit WIDTH-1: go to DONE, set bout = br_next, and leave diff holding the full result.
- Latency: out_valid is first high exactly WIDTH cycles after the accepting edge. in_ready is 0 throughout RUN and DONE.
- DONE:
  - out_valid = 1; diff and bout are held stable until the transfer.
  - On out_valid && out_ready: go to IDLE. in_ready rises the next cycle.
  - A new operand cannot be accepted in the same cycle as the result transfer.
  - out_ready held low holds the block in DONE indefinitely; there is no timeout.
- out_ready is ignored outside DONE.
- diff and bout keep their last values in IDLE. Consumers qualify them only with out_valid.
- rst high in any state, including mid-RUN, aborts the operation the same edge. No partial result is emitted, and the borrow is cleared so the next operation starts clean.
- Wrap-around: the difference is modulo 2^WIDTH and borrow is reported only via bout. Equal operands give diff = 0, bout = 0.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), the two's-complement signed overflow flag.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - Captured on the same edge as bout, valid with out_valid, reset to 0, held like diff.
- Not defined: port ovf and its register are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8; a=8'h05, b=8'h03, out_ready=1 -> out_valid exactly 8 cycles after the accept edge, diff=8'h02, bout=0; in_ready=1 the cycle after the transfer.
2. a=8'h03, b=8'h05 -> diff=8'hFE, bout=1. Then a=8'hFF, b=8'hFF -> diff=8'h00, bout=0, confirming the borrow does not leak between operations.
3. Backpressure: a=8'h40, b=8'h01, out_ready=0 for 5 cycles after out_valid rises -> diff=8'h3F held stable and in_ready=0. in_valid with a=8'h11 during this window is not accepted. After out_ready=1, the transfer occurs and in_ready=1 next cycle.
4. Reset mid-operation: accept a=8'h0F, b=8'hF0; assert rst for 1 cycle on the 4th RUN cycle -> out_valid never rises for that operation. Next op a=8'h10, b=8'h01 -> diff=8'h0F, bout=0.
5. Back-to-back: hold in_valid high with a new operand pair every possible cycle and out_ready=1 -> each accept is spaced WIDTH+2 cycles apart (WIDTH RUN + DONE + IDLE), and no operand is lost or duplicated.
6. SERIAL_SUB_OVF_EN defined:
   - a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bout=0.
   - a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, bout=1.
   - a=8'h05, b=8'h03 -> ovf=0.
